// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// One shared adder step per cycle, fixed SIZE+2 cycle latency.
module muldiv_unit #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [SIZE-1:0] rs1,
  input  logic [SIZE-1:0] rs2,
  output logic [SIZE-1:0] result,
  output logic            busy,
  output logic            done
);

  localparam int CW = $clog2(SIZE);
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  state_e state_q, state_d;
  logic accept;

  logic [2:0]        op_q;
  logic [SIZE-1:0]   m_q;
  logic [2*SIZE-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              qneg_q, rneg_q, dz_q;
  logic [SIZE-1:0]   result_q, result_d;

  logic            is_div, sa, sb, an, bn, dz;
  logic [SIZE-1:0] amag, bmag;

  logic [SIZE:0] add_a, add_b, add_s;
  logic          add_cin, ge;

  logic [2*SIZE-1:0] prod;
  logic [SIZE-1:0]   quo, rem;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and request acceptance
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CALC;
          accept  = 1'b1;
        end
      end
      S_CALC: if (cnt_q == LAST) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: begin
        if (start) begin
          state_d = S_CALC;
          accept  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand signedness and magnitudes for the incoming request
  always_comb begin
    is_div = op[2];
    sa     = is_div ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
    sb     = is_div ? ~op[0] : (op[1:0] == 2'b01);
    an     = sa & rs1[SIZE-1];
    bn     = sb & rs2[SIZE-1];
    amag   = an ? -rs1 : rs1;
    bmag   = bn ? -rs2 : rs2;
    dz     = is_div & (rs2 == '0);
  end

  // Shared SIZE+1 bit adder: add multiplicand or subtract divisor
  always_comb begin
    add_a   = {1'b0, acc_q[2*SIZE-1:SIZE]};
    add_b   = '0;
    add_cin = 1'b0;
    if (op_q[2]) begin
      add_a   = {1'b0, acc_q[2*SIZE-2:SIZE-1]};
      add_b   = {1'b0, ~m_q};
      add_cin = 1'b1;
    end else if (acc_q[0]) begin
      add_b = {1'b0, m_q};
    end
    add_s = add_a + add_b + {{SIZE{1'b0}}, add_cin};
    // A bit shifted out of the top means the partial
    // remainder already exceeds any SIZE-bit divisor.
    ge = acc_q[2*SIZE-1] | add_s[SIZE];
  end

  // Iteration datapath next state
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (accept) begin
      acc_d = {{SIZE{1'b0}}, (is_div ? amag : bmag)};
      cnt_d = '0;
    end else if (state_q == S_CALC) begin
      cnt_d = cnt_q + 1'b1;
      if (!op_q[2])
        acc_d = {add_s, acc_q[SIZE-1:1]};
      else if (ge)
        acc_d = {add_s[SIZE-1:0], acc_q[SIZE-2:0], 1'b1};
      else
        acc_d = {acc_q[2*SIZE-2:0], 1'b0};
    end
  end

  // Sign fix and field select, captured on the FIX->DONE edge
  always_comb begin
    prod = qneg_q ? -acc_q : acc_q;
    quo  = qneg_q ? -acc_q[SIZE-1:0] : acc_q[SIZE-1:0];
    rem  = rneg_q ? -acc_q[2*SIZE-1:SIZE] : acc_q[2*SIZE-1:SIZE];
    // Divide by zero returns all ones; the remainder already
    // reconstructs rs1 since rneg follows the dividend.
    if (dz_q) quo = '1;
    result_d = result_q;
    if (state_q == S_FIX) begin
      unique case (op_q)
        3'b000:                 result_d = prod[SIZE-1:0];
        3'b001, 3'b010, 3'b011: result_d = prod[2*SIZE-1:SIZE];
        3'b100, 3'b101:         result_d = quo;
        default:                result_d = rem;
      endcase
    end
  end

  // Datapath and request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= '0;
      m_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      if (accept) begin
        op_q   <= op;
        m_q    <= is_div ? bmag : amag;
        qneg_q <= (an ^ bn) & ~dz;
        rneg_q <= an;
        dz_q   <= dz;
      end
    end
  end

  assign result = result_q;
  assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
  assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against a
// plain-arithmetic RV32M reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic [31:0] result;
  logic        busy, done;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_unit #(.SIZE(32)) dut (
    .clk(clk), .reset(reset), .start(start),
    .op(op), .rs1(rs1), .rs2(rs2),
    .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_md(
    input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ubs;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    ubs = longint'(ub);
    p   = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ubs; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Issue one request and wait for done; lat is the done cycle, -1 on timeout
  task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] r,
                        output int lat, output int busy_bad);
    @(negedge clk);
    start = 1'b1; op = f; rs1 = a; rs2 = b;
    @(negedge clk);
    start = 1'b0;
    op = $urandom; rs1 = $urandom; rs2 = $urandom;
    lat = 1;
    busy_bad = 0;
    while (!done && lat < 60) begin
      if (!busy) busy_bad++;
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
    if (busy) busy_bad++;
    r = result;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = '0; rs1 = '0; rs2 = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, result} !== 34'h0) begin
      n_err++;
      $display("FAIL reset_state: busy=%b done=%b result=%h want 0 0 0",
               busy, done, result);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]  ops [12];
    logic [31:0] as  [12];
    logic [31:0] bs  [12];
    logic [31:0] exp [12];
    logic [31:0] r;
    int lat, bb;
    ops = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6,
            3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
    as  = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
            32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    bs  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF,
            32'hFFFF_FFFF, 32'd2, 32'd2, 32'd7, 32'd7,
            32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    exp = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE,
            32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
            32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5,
            32'h8000_0000, 32'd0};
    for (int i = 0; i < 12; i++) begin
      run_op(ops[i], as[i], bs[i], r, lat, bb);
      n_cmp++;
      if (r !== exp[i]) begin
        n_err++;
        $display("FAIL directed_%0d op=%0d: got %h want %h",
                 i, ops[i], r, exp[i]);
      end
      n_cmp++;
      if (lat !== 34 || bb !== 0) begin
        n_err++;
        $display("FAIL latency_%0d: done cycle %0d busy errs %0d want 34 0",
                 i, lat, bb);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a, b, r, e;
    logic [31:0] pick [5];
    int lat, bb;
    pick = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF};
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 4) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 4) == 0) ? pick[$urandom_range(0, 4)]
        : (($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 300))
                                        : $urandom);
      e = ref_md(f, a, b);
      run_op(f, a, b, r, lat, bb);
      n_cmp++;
      if (r !== e || lat !== 34) begin
        n_err++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: got %h lat %0d want %h lat 34",
                 i, f, a, b, r, lat, e);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] e;
    int cyc;
    e = ref_md(3'd4, 32'hFFFF_F000, 32'd13);
    @(negedge clk);
    start = 1'b1; op = 3'd4; rs1 = 32'hFFFF_F000; rs2 = 32'd13;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 60) begin
      if (cyc == 9) begin
        start = 1'b1; op = 3'd3; rs1 = 32'h1234_5678; rs2 = 32'h9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    n_cmp++;
    if (result !== e || cyc !== 34) begin
      n_err++;
      $display("FAIL ignore_start: got %h at cycle %0d want %h at 34",
               result, cyc, e);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_start_idle: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r, e1, e2;
    int lat, bb, cyc;
    e1 = ref_md(3'd1, 32'hDEAD_BEEF, 32'h1357_9BDF);
    e2 = ref_md(3'd6, 32'h8765_4321, 32'd1000);
    run_op(3'd1, 32'hDEAD_BEEF, 32'h1357_9BDF, r, lat, bb);
    n_cmp++;
    if (r !== e1 || lat !== 34) begin
      n_err++;
      $display("FAIL b2b_first: got %h lat %0d want %h lat 34", r, lat, e1);
    end
    start = 1'b1; op = 3'd6; rs1 = 32'h8765_4321; rs2 = 32'd1000;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (result !== e2 || cyc !== 34) begin
      n_err++;
      $display("FAIL b2b_second: got %h after %0d cycles want %h after 34",
               result, cyc, e2);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r, e;
    int lat, bb, ndone;
    @(negedge clk);
    start = 1'b1; op = 3'd4; rs1 = 32'd1000; rs2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({busy, done, result} !== 34'h0) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h want 0 0 0",
               busy, done, result);
    end
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    n_cmp++;
    if (ndone !== 0) begin
      n_err++;
      $display("FAIL reset_no_done: activity cycles %0d want 0", ndone);
    end
    e = ref_md(3'd7, 32'hCAFE_F00D, 32'd77);
    run_op(3'd7, 32'hCAFE_F00D, 32'd77, r, lat, bb);
    n_cmp++;
    if (r !== e || lat !== 34 || bb !== 0) begin
      n_err++;
      $display("FAIL reset_recover: got %h lat %0d want %h lat 34", r, lat, e);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
